// File: rtl/din7seg_mux.sv
// Multiplexed 7-segment driver: digit scan, hex decode, brightness PWM with a dark guard
// sub-step, leading-zero suppression and frame-aligned shadow latching of the display data.
module din7seg_mux #(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned IN_CLOCK    = 50_000_000,
  parameter int unsigned REFRESH_HZ  = 100,
  parameter int unsigned STEP_CYC    = IN_CLOCK / (REFRESH_HZ * DIGITS * 16),
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          DIG_ACT_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic [3:0]            bright,
  input  logic                  lz_en,
  input  logic                  freeze,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     DIG,
  output logic                  frame_start
);

  localparam int SW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam int DW = $clog2(DIGITS);
  localparam logic [7:0]        SEG_INV = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_INV = {DIGITS{DIG_ACT_LOW}};

  logic [SW-1:0]       step_q, step_d;
  logic [3:0]          sub_q, sub_d;
  logic [DW-1:0]       digit_q, digit_d;
  logic [4*DIGITS-1:0] data_sh_q;
  logic [DIGITS-1:0]   dp_sh_q, blank_sh_q;
  logic                lz_sh_q;
  logic                boot_q;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic                fs_q, fs_d;

  logic                step_wrap, sub_wrap, frame_wrap, load;
  logic                drive, run;
  logic [DIGITS-1:0]   supp, dig_1h;
  logic [3:0]          nib;
  logic [7:0]          seg_on;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    step_wrap  = (step_q == SW'(STEP_CYC - 1));
    sub_wrap   = step_wrap && (sub_q == 4'hF);
    frame_wrap = sub_wrap && (digit_q == DW'(DIGITS - 1));
    step_d     = step_wrap ? '0 : step_q + 1'b1;
    sub_d      = step_wrap ? sub_q + 4'd1 : sub_q;
    digit_d    = sub_wrap ? (frame_wrap ? '0 : digit_q + 1'b1) : digit_q;
    // Shadow reload coincides with the dark guard step of digit 0, so no torn frame is shown.
    load       = boot_q || (frame_wrap && !freeze);
  end

  // Leading-zero scan from the most significant digit down; digit 0 always shows.
  always_comb begin
    supp = '0;
    run  = lz_sh_q;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (run && (data_sh_q[4*i +: 4] == 4'h0) && !dp_sh_q[i]) supp[i] = 1'b1;
      else run = 1'b0;
    end
  end

  always_comb begin
    nib    = data_sh_q[{digit_q, 2'b00} +: 4];
    drive  = (sub_q != 4'd0) && (sub_q <= bright);
    seg_on = (blank_sh_q[digit_q] || supp[digit_q]) ? 8'h00 : {dp_sh_q[digit_q], hex7(nib)};
    dig_1h = '0;
    dig_1h[digit_q] = 1'b1;
    seg_d  = (drive ? seg_on : 8'h00) ^ SEG_INV;
    dig_d  = (drive ? dig_1h : '0) ^ DIG_INV;
    fs_d   = (step_q == '0) && (sub_q == 4'd0) && (digit_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q     <= '0;
      sub_q      <= '0;
      digit_q    <= '0;
      data_sh_q  <= '0;
      dp_sh_q    <= '0;
      blank_sh_q <= '0;
      lz_sh_q    <= 1'b0;
      boot_q     <= 1'b1;
      seg_q      <= SEG_INV;
      dig_q      <= DIG_INV;
      fs_q       <= 1'b0;
    end else begin
      step_q  <= step_d;
      sub_q   <= sub_d;
      digit_q <= digit_d;
      boot_q  <= 1'b0;
      if (load) begin
        data_sh_q  <= data;
        dp_sh_q    <= dp;
        blank_sh_q <= blank;
        lz_sh_q    <= lz_en;
      end
      seg_q <= seg_d;
      dig_q <= dig_d;
      fs_q  <= fs_d;
    end
  end

  assign SEG         = seg_q;
  assign DIG         = dig_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_din7seg_mux.sv
// Bench for din7seg_mux (4 digits, 2 cycles per sub-step): a frame-phase reference model
// fills an expected queue every clock; directed steps add targeted window checks.
module tb_din7seg_mux;
  localparam int DIGITS = 4;
  localparam int STEP   = 2;
  localparam int SLOT   = 16 * STEP;
  localparam int FRAME  = DIGITS * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0, blank = '0, bright = 4'd15;
  logic        lz_en = 1'b0, freeze = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame_start;

  din7seg_mux #(.DIGITS(DIGITS), .STEP_CYC(STEP), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .blank(blank), .bright(bright),
    .lz_en(lz_en), .freeze(freeze), .SEG(seg), .DIG(dig), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int k = 0;
  logic [12:0] exp_q[$];
  logic [6:0]  seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [15:0] sh_data = '0;
  logic [3:0]  sh_dp = '0, sh_blank = '0;
  logic        sh_lz = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at k=%0d", tag, obs, expv, k);
    end
  endtask

  // Expected {frame_start, DIG, SEG} for the counter phase p within a frame.
  function automatic logic [12:0] model_out(input int p);
    int d, s;
    logic sup;
    logic [7:0] on;
    d = p / SLOT;
    s = (p / STEP) % 16;
    if (s == 0 || s > int'(bright)) return {(p == 0), 4'hF, 8'hFF};
    sup = sh_lz && (d > 0);
    for (int j = d; j < DIGITS; j++)
      if (sh_data[4*j +: 4] != 4'h0 || sh_dp[j]) sup = 1'b0;
    on = (sh_blank[d] || sup) ? 8'h00 : {sh_dp[d], seg_tbl[sh_data[4*d +: 4]]};
    return {1'b0, ~(4'b0001 << d), ~on};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0;
      sh_data = '0; sh_dp = '0; sh_blank = '0; sh_lz = 1'b0;
      exp_q.delete();
    end else begin
      exp_q.push_back(model_out(k % FRAME));
      k++;
      if (k == 1 || (k % FRAME == 0 && !freeze)) begin
        sh_data = data; sh_dp = dp; sh_blank = blank; sh_lz = lz_en;
      end
    end
  end

  always @(negedge clk) begin
    logic [12:0] e;
    if (!rst_n || exp_q.size() == 0) e = {1'b0, 4'hF, 8'hFF};
    else e = exp_q.pop_front();
    check("scan", {3'b000, frame_start, dig, seg}, {3'b000, e});
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_out_phase(input int p);
    bit found = 1'b0;
    for (int i = 0; i < FRAME + 2 && !found; i++) begin
      @(negedge clk);
      if (k > 0 && (k - 1) % FRAME == p) found = 1'b1;
    end
    check("wait_phase", {15'd0, found}, 16'd1);
  endtask

  task automatic new_frame();
    cycles(2);
    wait_out_phase(0);
  endtask

  int cnt;

  initial begin
    #1 rst_n = 1'b0;
    cycles(3);
    check("rst_seg", {8'h0, seg}, 16'h00FF);
    check("rst_dig", {12'h0, dig}, 16'h000F);
    check("rst_fs", {15'h0, frame_start}, 16'h0000);

    data = 16'h1A3F; dp = 4'b0010; bright = 4'd15;
    #2 rst_n = 1'b1;
    wait_out_phase(0);
    check("fs_first", {15'h0, frame_start}, 16'h0001);
    wait_out_phase(2);
    check("d0_dig", {12'h0, dig}, 16'h000E);
    check("d0_seg", {8'h0, seg}, 16'h008E);
    wait_out_phase(SLOT + 1);
    check("d1_guard", {12'h0, dig}, 16'h000F);
    cycles(1);
    check("d1_dig", {12'h0, dig}, 16'h000D);
    check("d1_seg", {8'h0, seg}, 16'h0030);
    wait_out_phase(3 * SLOT + 2);
    check("d3_seg", {8'h0, seg}, 16'h00F9);
    wait_out_phase(0);
    cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (frame_start) cnt++;
    end
    check("fs_count", 16'(cnt), 16'd2);

    bright = 4'd4;
    wait_out_phase(FRAME - 1);
    cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (dig != 4'hF) cnt++;
    end
    check("pwm4_on", 16'(cnt), 16'd32);
    bright = 4'd0;
    wait_out_phase(FRAME - 1);
    cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (dig != 4'hF) cnt++;
    end
    check("pwm0_on", 16'(cnt), 16'd0);
    bright = 4'd15;

    data = 16'h0005; dp = 4'b0000; lz_en = 1'b1;
    new_frame();
    wait_out_phase(2);
    check("lz_d0", {8'h0, seg}, 16'h0092);
    wait_out_phase(3 * SLOT + 2);
    check("lz_d3_dig", {12'h0, dig}, 16'h0007);
    check("lz_d3_seg", {8'h0, seg}, 16'h00FF);
    data = 16'h0000;
    new_frame();
    wait_out_phase(2);
    check("lz_zero_d0", {8'h0, seg}, 16'h00C0);
    wait_out_phase(SLOT + 2);
    check("lz_zero_d1", {8'h0, seg}, 16'h00FF);
    data = 16'h0005; dp = 4'b0100;
    new_frame();
    wait_out_phase(2 * SLOT + 2);
    check("lz_dp_d2", {8'h0, seg}, 16'h0040);
    wait_out_phase(3 * SLOT + 2);
    check("lz_dp_d3", {8'h0, seg}, 16'h00FF);

    lz_en = 1'b0; dp = 4'b0000; blank = 4'b0010; data = 16'h1234;
    new_frame();
    wait_out_phase(SLOT + 2);
    check("blank_d1_dig", {12'h0, dig}, 16'h000D);
    check("blank_d1_seg", {8'h0, seg}, 16'h00FF);
    blank = 4'b0000;
    wait_out_phase(SLOT + 10);
    data = 16'($urandom_range(0, 65535));
    cycles(FRAME);
    data = 16'($urandom_range(0, 65535));
    bright = 4'($urandom_range(1, 15));
    cycles(FRAME);
    bright = 4'd15;

    data = 16'h1234;
    new_frame();
    freeze = 1'b1; data = 16'h5678;
    new_frame();
    wait_out_phase(2);
    check("freeze_old", {8'h0, seg}, 16'h0099);
    freeze = 1'b0;
    new_frame();
    wait_out_phase(2);
    check("freeze_new", {8'h0, seg}, 16'h0080);

    wait_out_phase(2 * SLOT + 10);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_seg", {8'h0, seg}, 16'h00FF);
    check("mid_rst_dig", {12'h0, dig}, 16'h000F);
    check("mid_rst_fs", {15'h0, frame_start}, 16'h0000);
    cycles(3);
    #2 rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cnt++;
      if (dig != 4'hF) break;
    end
    check("first_on_cycle", 16'(cnt), 16'd3);
    check("first_on_dig", {12'h0, dig}, 16'h000E);
    cycles(FRAME + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
